// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial ripple-borrow subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int unsigned SUB_WIDTH_DEFAULT = 4;

    // Counter width needed to index WIDTH bit positions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Full subtractor cell built from two half subtractors and an OR of their borrows.
module full_subtractor (
    output logic d,
    output logic bout,
    input  logic x,
    input  logic y,
    input  logic bin
);

    logic d1;
    logic b1;
    logic b2;

    half_subtractor u_hs_xy (
        .d    (d1),
        .bout (b1),
        .x    (x),
        .y    (y)
    );

    half_subtractor u_hs_bin (
        .d    (d),
        .bout (b2),
        .x    (d1),
        .y    (bin)
    );

    always_comb begin
        bout = b1 | b2;
    end

endmodule

// File: rtl/half_subtractor.sv
// Half subtractor cell: d = x - y, bout set when x < y.
module half_subtractor (
    output logic d,
    output logic bout,
    input  logic x,
    input  logic y
);

    always_comb begin
        d    = x ^ y;
        bout = ~x & y;
    end

endmodule

// File: rtl/serial_borrow_subtractor.sv
// Bit-serial A - B, LSB first, one full-subtractor cell reused over WIDTH cycles.
// Optional signed-overflow output enabled by defining SUB_OVF_FLAG_EN.
module serial_borrow_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SUB_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
    logic             borrow_q, borrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             d_bit;
    logic             bout_bit;

`ifdef SUB_OVF_FLAG_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
`endif

    full_subtractor u_fs (
        .d    (d_bit),
        .bout (bout_bit),
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .bin  (borrow_q)
    );

    always_comb begin
        state_d   = state_q;
        a_sr_d    = a_sr_q;
        b_sr_d    = b_sr_q;
        diff_sr_d = diff_sr_q;
        borrow_d  = borrow_q;
        cnt_d     = cnt_q;
`ifdef SUB_OVF_FLAG_EN
        a_msb_d   = a_msb_q;
        b_msb_d   = b_msb_q;
        ovf_d     = ovf_q;
`endif
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);

        case (state_q)
            IDLE: begin
                // diff_sr keeps the previous result until the first BUSY shift.
                if (in_valid) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
`ifdef SUB_OVF_FLAG_EN
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b[WIDTH-1];
`endif
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                diff_sr_d = {d_bit, diff_sr_q[WIDTH-1:1]};
                a_sr_d    = a_sr_q >> 1;
                b_sr_d    = b_sr_q >> 1;
                borrow_d  = bout_bit;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
`ifdef SUB_OVF_FLAG_EN
                    // d_bit is the difference MSB on the final shift.
                    ovf_d   = (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            diff_sr_q <= '0;
            borrow_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            a_sr_q    <= a_sr_d;
            b_sr_q    <= b_sr_d;
            diff_sr_q <= diff_sr_d;
            borrow_q  <= borrow_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef SUB_OVF_FLAG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign diff       = diff_sr_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Directed, table-driven bench for serial_borrow_subtractor (WIDTH=4).
module tb_serial_borrow_subtractor;

    localparam int unsigned W = 4;
    localparam int unsigned MAX_WAIT = 20;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_diff;
        logic         exp_borrow;
        logic         exp_ovf;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SUB_OVF_FLAG_EN
    logic         ovf;
`endif

    int unsigned errors;
    int unsigned checks;

    serial_borrow_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SUB_OVF_FLAG_EN
        ,
        .ovf        (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for out_valid and returns the number of edges it took.
    task automatic wait_result(output int unsigned cycles);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < MAX_WAIT) begin
            step();
            cycles = cycles + 1;
        end
        if (out_valid !== 1'b1) begin
            chk("result_timeout", 32'(out_valid), 32'd1);
        end
    endtask

    task automatic run_op(input vec_t v);
        int unsigned cyc;
        a        = v.a;
        b        = v.b;
        in_valid = 1'b1;
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        wait_result(cyc);
        chk("latency", cyc, W);
        chk("diff", 32'(diff), 32'(v.exp_diff));
        chk("borrow_out", 32'(borrow_out), 32'(v.exp_borrow));
`ifdef SUB_OVF_FLAG_EN
        chk("ovf", 32'(ovf), 32'(v.exp_ovf));
`endif
        chk("in_ready_done", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("out_valid_after_ack", 32'(out_valid), 32'd0);
        chk("in_ready_after_ack", 32'(in_ready), 32'd1);
        chk("diff_hold_idle", 32'(diff), 32'(v.exp_diff));
    endtask

    vec_t vecs[10];

    initial begin
        int unsigned cyc;
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        vecs[0] = '{4'd9,  4'd3,  4'h6, 1'b0, 1'b1};
        vecs[1] = '{4'd3,  4'd9,  4'hA, 1'b1, 1'b1};
        vecs[2] = '{4'd0,  4'd0,  4'h0, 1'b0, 1'b0};
        vecs[3] = '{4'd15, 4'd15, 4'h0, 1'b0, 1'b0};
        vecs[4] = '{4'd0,  4'd1,  4'hF, 1'b1, 1'b0};
        vecs[5] = '{4'd5,  4'd2,  4'h3, 1'b0, 1'b0};
        vecs[6] = '{4'd7,  4'd8,  4'hF, 1'b1, 1'b1};
        vecs[7] = '{4'd12, 4'd5,  4'h7, 1'b0, 1'b1};
        vecs[8] = '{4'd8,  4'd1,  4'h7, 1'b0, 1'b1};
        vecs[9] = '{4'd7,  4'd1,  4'h6, 1'b0, 1'b0};

        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow_out), 32'd0);
`ifdef SUB_OVF_FLAG_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i]);
        end

        // Back-pressure with a held in_valid carrying the next operands.
        a        = 4'd9;
        b        = 4'd3;
        in_valid = 1'b1;
        step();
        a = 4'd3;
        b = 4'd9;
        wait_result(cyc);
        chk("bp_latency", cyc, W);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_diff_stable", 32'(diff), 32'h6);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_idle", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_diff", 32'(diff), 32'h6);
        step();
        in_valid = 1'b0;
        chk("bp_next_accept", 32'(in_ready), 32'd0);
        wait_result(cyc);
        chk("bp_next_diff", 32'(diff), 32'hA);
        chk("bp_next_borrow", 32'(borrow_out), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset after two BUSY cycles aborts the operation.
        a        = 4'd9;
        b        = 4'd3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("mid_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_diff", 32'(diff), 32'd0);
        chk("mid_rst_borrow", 32'(borrow_out), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef SUB_OVF_FLAG_EN
        chk("mid_rst_ovf", 32'(ovf), 32'd0);
`endif
        #3;
        rst_n = 1'b1;
        step();
        run_op(vecs[5]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
